conv_chan_accum: RTL and testbench

Per-pixel channel accumulator placed directly downstream of the 26-input add tree in the convolution datapath. Each add-tree output is the partial sum of one input channel for one output pixel. This block adds IN_CH consecutive partial sums plus a per-pixel bias, then saturates the total to WIDTH bits. It optionally applies ReLU and buffers finished pixels in a small FIFO with a valid/ready output handshake. `in_ready` gives upstream a credit that covers the add tree's 5-cycle in-flight window.

---
 rtl/conv_chan_accum.sv | 156 +++++++++++++++
 tb/tb_conv_chan_accum.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_chan_accum.sv
// conv_chan_accum: per-pixel channel accumulator behind the convolution add tree.
// It sums IN_CH partial sums plus a per-pixel bias, saturates the total to WIDTH bits,
// and buffers finished pixels in a DEPTH-entry FIFO with a valid/ready output.
// Optional feature: define CONV_RELU_EN to clamp negative results to zero before the push.
module conv_chan_accum #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IN_CH = 6,
  parameter int unsigned ACC_W = WIDTH + 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sum_valid,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] bias_in,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             ovf_err
);

  localparam int unsigned CntW = $clog2(IN_CH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic {StFirst, StAccum} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          ch_cnt_q, ch_cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  sum_ext, bias_ext, acc_next;
  logic                     finish;
  logic [WIDTH-1:0]         sat_val, res_val;

  logic [WIDTH-1:0]         mem_q [DEPTH];
  logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]          count_q, count_d;
  logic                     in_ready_q, ovf_err_q;
  logic                     full, push, pop, ovf_set;

  assign sum_ext  = {{(ACC_W-WIDTH){sum_in[WIDTH-1]}}, sum_in};
  assign bias_ext = {{(ACC_W-WIDTH){bias_in[WIDTH-1]}}, bias_in};

  // The first channel starts from the bias; later channels add onto the running total.
  assign acc_next = (state_q == StFirst) ? (bias_ext + sum_ext) : (acc_q + sum_ext);

  // Channel FSM: next state, channel counter, accumulator and finish strobe.
  always_comb begin
    state_d  = state_q;
    ch_cnt_d = ch_cnt_q;
    acc_d    = acc_q;
    finish   = 1'b0;
    if (sum_valid) begin
      acc_d = acc_next;
      unique case (state_q)
        StFirst: begin
          if (IN_CH == 1) begin
            finish   = 1'b1;
            ch_cnt_d = '0;
          end else begin
            ch_cnt_d = CntW'(1);
            state_d  = StAccum;
          end
        end
        StAccum: begin
          if (ch_cnt_q == CntW'(IN_CH - 1)) begin
            finish   = 1'b1;
            ch_cnt_d = '0;
            state_d  = StFirst;
          end else begin
            ch_cnt_d = ch_cnt_q + CntW'(1);
          end
        end
        default: state_d = StFirst;
      endcase
    end
  end

  // Channel FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFirst;
      ch_cnt_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      ch_cnt_q <= ch_cnt_d;
      acc_q    <= acc_d;
    end
  end

  // Saturate the finished total to WIDTH bits, then optionally rectify.
  always_comb begin
    if (acc_next > SatMax) begin
      sat_val = SatMax[WIDTH-1:0];
    end else if (acc_next < SatMin) begin
      sat_val = SatMin[WIDTH-1:0];
    end else begin
      sat_val = acc_next[WIDTH-1:0];
    end
`ifdef CONV_RELU_EN
    res_val = sat_val[WIDTH-1] ? '0 : sat_val;
`else
    res_val = sat_val;
`endif
  end

  assign full      = (count_q == LvlW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push      = finish && (!full || pop);
  assign ovf_set   = finish && full && !pop;

  // FIFO occupancy for the coming cycle.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + LvlW'(1);
    end else if (pop && !push) begin
      count_d = count_q - LvlW'(1);
    end
  end

  // FIFO pointers, occupancy, credit and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      ovf_err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      // Keep 5 slots for sums in flight in the add tree plus one for the pixel in progress.
      in_ready_q <= (count_d <= LvlW'(DEPTH - 6));
      if (ovf_set) ovf_err_q <= 1'b1;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= res_val;
  end

  assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
  assign in_ready = in_ready_q;
  assign ovf_err  = ovf_err_q;

endmodule

// File: tb/tb_conv_chan_accum.sv
// Testbench for conv_chan_accum: a 3-channel instance and a 1-channel instance,
// table-driven pixel vectors, hand-written backpressure/overflow/reset sequences,
// and a randomized run against a queue-based reference model.
module tb_conv_chan_accum;

  localparam int W = 16;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         v3, ordy3, irdy3, oval3, oerr3;
  logic [W-1:0] sum3, bias3, odat3;
  logic         v1, ordy1, irdy1, oval1, oerr1;
  logic [W-1:0] sum1, bias1, odat1;

  conv_chan_accum #(.WIDTH(W), .IN_CH(3), .DEPTH(D)) u_dut3 (
    .clk(clk), .rst(rst), .sum_valid(v3), .sum_in(sum3), .bias_in(bias3),
    .in_ready(irdy3), .out_valid(oval3), .out_data(odat3), .out_ready(ordy3),
    .ovf_err(oerr3)
  );

  conv_chan_accum #(.WIDTH(W), .IN_CH(1), .DEPTH(D)) u_dut1 (
    .clk(clk), .rst(rst), .sum_valid(v1), .sum_in(sum1), .bias_in(bias1),
    .in_ready(irdy1), .out_valid(oval1), .out_data(odat1), .out_ready(ordy1),
    .ovf_err(oerr1)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    string name;
    int    bias;
    int    s0;
    int    s1;
    int    s2;
    int    exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    v3 = 1'b0;
    v1 = 1'b0;
    step();
    rst = 1'b0;
  endtask

  function automatic int relu(input int v);
`ifdef CONV_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  initial begin
    int q[$];
    int n, tot, val;
    bit ovf, pop, fin, full_pre;

    rst = 1'b1;
    v3 = 1'b0; sum3 = '0; bias3 = '0; ordy3 = 1'b0;
    v1 = 1'b0; sum1 = '0; bias1 = '0; ordy1 = 1'b0;
    step();
    do_reset();

    // Reset state of both instances.
    check("rst out_valid3", int'(oval3), 0);
    check("rst out_data3", int'(odat3), 0);
    check("rst in_ready3", int'(irdy3), 1);
    check("rst ovf_err3", int'(oerr3), 0);
    check("rst out_valid1", int'(oval1), 0);
    check("rst in_ready1", int'(irdy1), 1);

    // Table of 3-channel pixels.
    vecs[0] = '{"basic", 10, 100, 200, -50, 260};
    vecs[1] = '{"negative", 0, -100, -100, -100, relu(-300)};
    vecs[2] = '{"sat_pos", 0, 30000, 30000, 30000, 32767};
    vecs[3] = '{"sat_neg", 0, -30000, -30000, -30000, relu(-32768)};
    vecs[4] = '{"no_mid_sat", 32767, 32767, -32768, -32768, relu(-2)};
    vecs[5] = '{"bias_min", -32768, -1, 0, 0, relu(-32768)};

    ordy3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      v3 = 1'b1;
      bias3 = W'(vecs[i].bias);
      sum3 = W'(vecs[i].s0);
      step();
      bias3 = 16'h5555;  // bias must be ignored after the first channel
      sum3 = W'(vecs[i].s1);
      step();
      sum3 = W'(vecs[i].s2);
      step();
      v3 = 1'b0;
      check({vecs[i].name, " valid"}, int'(oval3), 1);
      check(vecs[i].name, int'($signed(odat3)), vecs[i].exp);
      step();
      check({vecs[i].name, " drained"}, int'(oval3), 0);
    end

    // Reset mid-pixel: the abandoned partial sum must never appear.
    v3 = 1'b1; bias3 = '0; sum3 = W'(500);
    step();
    step();
    v3 = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst no output", int'(oval3), 0);
    v3 = 1'b1; bias3 = W'(1); sum3 = W'(1);
    step();
    step();
    step();
    v3 = 1'b0;
    check("midrst valid", int'(oval3), 1);
    check("midrst data", int'($signed(odat3)), 4);
    step();
    check("midrst single", int'(oval3), 0);

    // Backpressure on the 1-channel instance.
    ordy1 = 1'b0;
    v1 = 1'b1; bias1 = W'(1); sum1 = W'(7);
    step();
    sum1 = W'(-8);
    step();
    check("bp ready at 2", int'(irdy1), 1);
    sum1 = W'(9);
    step();
    v1 = 1'b0;
    step();
    check("bp ready low", int'(irdy1), 0);
    check("bp valid", int'(oval1), 1);
    check("bp head0", int'($signed(odat1)), 8);
    step();
    check("bp head stable", int'($signed(odat1)), 8);
    ordy1 = 1'b1;
    step();
    check("bp head1", int'($signed(odat1)), relu(-7));
    step();
    check("bp head2", int'($signed(odat1)), 10);
    step();
    check("bp empty", int'(oval1), 0);
    check("bp ready back", int'(irdy1), 1);
    check("bp no ovf", int'(oerr1), 0);

    // Overflow: nine pixels into an eight-entry FIFO with no pops.
    do_reset();
    ordy1 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      v1 = 1'b1; bias1 = '0; sum1 = W'(k);
      step();
      if (k == 8) check("ovf clear at 8", int'(oerr1), 0);
    end
    v1 = 1'b0;
    check("ovf set at 9", int'(oerr1), 1);
    step();
    step();
    check("ovf sticky", int'(oerr1), 1);
    ordy1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check("ovf drain valid", int'(oval1), 1);
      check("ovf drain data", int'($signed(odat1)), k);
      step();
    end
    check("ovf drained", int'(oval1), 0);
    check("ovf sticky after drain", int'(oerr1), 1);
    do_reset();
    check("ovf cleared by rst", int'(oerr1), 0);

    // Randomized run on the 3-channel instance against a queue model.
    do_reset();
    q.delete();
    n = 0; tot = 0; ovf = 1'b0;
    for (int i = 0; i < 600; i++) begin
      v3 = irdy3 ? (($urandom % 3) != 0) : (($urandom % 8) == 0);
      sum3 = W'($urandom);
      bias3 = W'($urandom);
      ordy3 = (i < 300) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);

      full_pre = (q.size() == D);
      pop = (q.size() > 0) && ordy3;
      fin = 1'b0;
      val = 0;
      if (v3) begin
        if (n == 0) tot = int'($signed(bias3));
        tot = tot + int'($signed(sum3));
        n++;
        if (n == 3) begin
          fin = 1'b1;
          val = relu(sat16(tot));
          n = 0;
        end
      end
      if (pop) void'(q.pop_front());
      if (fin) begin
        if (!full_pre || pop) q.push_back(val);
        else ovf = 1'b1;
      end

      step();
      check("rand valid", int'(oval3), (q.size() != 0) ? 1 : 0);
      if (q.size() != 0) check("rand data", int'($signed(odat3)), q[0]);
      check("rand in_ready", int'(irdy3), (q.size() <= D - 6) ? 1 : 0);
      check("rand ovf", int'(oerr3), int'(ovf));
    end
    v3 = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
